wash_motor_drv: RTL

- Motor-side end of the wash controller's motor command interface.
- Accepts the 3-bit motor code (0 stop, 1 clockwise, 2 counterclockwise) and drives an H-bridge with two PWM inputs.
- Adds soft-start and soft-stop duty ramps, plus a mandatory dead time before any direction is energized, so direction reversals never shoot through.
- Reports applied direction, current duty and a ready flag back to the controller.

---
 rtl/wash_motor_if.sv | 14 +
 rtl/wash_motor_drv.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wash_motor_if.sv
// Motor command interface between the wash controller (master) and the
// motor-side driver (slave): request code out, applied status back.
interface wash_motor_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          motor;
    logic [1:0]          dir;
    logic [PWM_BITS-1:0] duty;
    logic                ready;
    logic                fault;

    modport master (output motor, input dir, duty, ready, fault);
    modport slave  (input motor, output dir, duty, ready, fault);
endinterface

// File: rtl/wash_motor_drv.sv
// H-bridge motor driver: soft-start/soft-stop duty ramps with a dead time
// before every energized direction so reversals can never shoot through.
module wash_motor_drv #(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 8,
    parameter int DUTY_MAX  = 240,
    parameter int DEAD      = 16,
    parameter int DEAD_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    wash_motor_if.slave cmd,
    output logic        in_a,
    output logic        in_b
);
    typedef enum logic [2:0] {
        S_OFF,
        S_DEAD,
        S_RAMP_UP,
        S_RUN,
        S_RAMP_DN
    } state_t;

    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(RAMP_STEP);
    localparam logic [PWM_BITS-1:0] DMAX    = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [DEAD_W-1:0]   DEAD_LD = DEAD_W'(DEAD);
    localparam logic [1:0]          DIR_OFF = 2'd0;
    localparam logic [1:0]          DIR_CW  = 2'd1;
    localparam logic [1:0]          DIR_CCW = 2'd2;

    state_t              state, state_n;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q, duty_n;
    logic [1:0]          dir_q, dir_n;
    logic [1:0]          tgt_q, tgt_n;
    logic [1:0]          req;
    logic [DEAD_W-1:0]   dead_q, dead_n;
    logic                pe;
    logic                pwm_on;
    logic                fault_q;
    logic                ready_q;

    assign pe       = (pwm_cnt == CNT_MAX);
    assign pwm_on   = (pwm_cnt < duty_q);
    assign cmd.dir   = dir_q;
    assign cmd.duty  = duty_q;
    assign cmd.ready = ready_q;
    assign cmd.fault = fault_q;

    // Invalid codes 3..7 collapse onto stop.
    always_comb begin
        req = DIR_OFF;
        if (cmd.motor == 3'd1)
            req = DIR_CW;
        else if (cmd.motor == 3'd2)
            req = DIR_CCW;
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        duty_n  = duty_q;
        tgt_n   = tgt_q;
        dead_n  = dead_q;
        case (state)
            S_OFF: begin
                if (req != DIR_OFF) begin
                    tgt_n   = req;
                    dead_n  = DEAD_LD;
                    state_n = S_DEAD;
                end
            end
            S_DEAD: begin
                if (req == DIR_OFF) begin
                    state_n = S_OFF;
                end else begin
                    tgt_n = req;
                    if (dead_q == '0) begin
                        dir_n   = tgt_n;
                        state_n = S_RAMP_UP;
                    end else begin
                        dead_n = dead_q - 1'b1;
                    end
                end
            end
            S_RAMP_UP: begin
                // A changed request wins over a coinciding period-end step.
                if (req != dir_q) begin
                    state_n = S_RAMP_DN;
                end else if (duty_q >= DMAX) begin
                    state_n = S_RUN;
                end else if (pe) begin
                    if (DMAX - duty_q <= STEP) begin
                        duty_n  = DMAX;
                        state_n = S_RUN;
                    end else begin
                        duty_n = duty_q + STEP;
                    end
                end
            end
            S_RUN: begin
                if (req != dir_q)
                    state_n = S_RAMP_DN;
            end
            S_RAMP_DN: begin
                if (req == dir_q) begin
                    state_n = S_RAMP_UP;
                end else if (pe) begin
                    if (duty_q > STEP) begin
                        duty_n = duty_q - STEP;
                    end else begin
                        // Bridge is fully off: only now may the direction drop.
                        duty_n = '0;
                        dir_n  = DIR_OFF;
                        if (req != DIR_OFF) begin
                            tgt_n   = req;
                            dead_n  = DEAD_LD;
                            state_n = S_DEAD;
                        end else begin
                            state_n = S_OFF;
                        end
                    end
                end
            end
            default: state_n = S_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OFF;
            dir_q   <= DIR_OFF;
            duty_q  <= '0;
            tgt_q   <= DIR_OFF;
            dead_q  <= '0;
            pwm_cnt <= '0;
            in_a    <= 1'b0;
            in_b    <= 1'b0;
            fault_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            dir_q   <= dir_n;
            duty_q  <= duty_n;
            tgt_q   <= tgt_n;
            dead_q  <= dead_n;
            pwm_cnt <= pwm_cnt + 1'b1;
            in_a    <= (dir_q == DIR_CW) && pwm_on;
            in_b    <= (dir_q == DIR_CCW) && pwm_on;
            ready_q <= (state_n == S_OFF) || (state_n == S_RUN);
            if (cmd.motor > 3'd2)
                fault_q <= 1'b1;
            else if (cmd.motor == 3'd0)
                fault_q <= 1'b0;
        end
    end
endmodule
